// File: rtl/path_pulse_filter_if.sv
// Signal bundle for one delayed specify path: source-side inputs and the
// filtered, delayed outputs seen by downstream timing-check logic.
interface path_pulse_filter_if;
  logic in_sig;
  logic ondetect;
  logic out_sig;
  logic out_err;
  logic cancel_pulse;
  logic busy;

  modport master (
    output in_sig,
    output ondetect,
    input  out_sig,
    input  out_err,
    input  cancel_pulse,
    input  busy
  );

  modport slave (
    input  in_sig,
    input  ondetect,
    output out_sig,
    output out_err,
    output cancel_pulse,
    output busy
  );
endinterface

// File: rtl/path_pulse_filter.sv
// Cycle-based single specify path (in => out) with separate rise/fall delays,
// inertial pulse rejection and ondetect/onevent showcancelled error marking.
module path_pulse_filter #(
  parameter int RISE_DLY   = 4,
  parameter int FALL_DLY   = 6,
  parameter int REJECT_LIM = 2,
  parameter int CNT_W      = 8
) (
  input logic clk,
  input logic rst,
  path_pulse_filter_if.slave pif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    ERR_WAIT = 2'd2,
    ERR      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RISE_C = CNT_W'(RISE_DLY);
  localparam logic [CNT_W-1:0] FALL_C = CNT_W'(FALL_DLY);
  localparam logic [CNT_W-1:0] REJ_C  = CNT_W'(REJECT_LIM);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] clr_q, clr_d;
  logic             tgt_q, tgt_d;
  logic             mode_q, mode_d;
  logic             out_sig_q, out_sig_d;
  logic             out_err_q, out_err_d;
  logic             cancel_q, cancel_d;

  function automatic logic [CNT_W-1:0] dly(input logic v);
    return v ? RISE_C : FALL_C;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clr_q     <= '0;
      tgt_q     <= 1'b0;
      mode_q    <= 1'b0;
      out_sig_q <= 1'b0;
      out_err_q <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_q     <= clr_d;
      tgt_q     <= tgt_d;
      mode_q    <= mode_d;
      out_sig_q <= out_sig_d;
      out_err_q <= out_err_d;
      cancel_q  <= cancel_d;
    end
  end

  // cnt tracks edges elapsed since the leading transition was sampled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    tgt_d     = tgt_q;
    mode_d    = mode_q;
    out_sig_d = out_sig_q;
    out_err_d = out_err_q;
    cancel_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pif.in_sig != out_sig_q) begin
          tgt_d   = pif.in_sig;
          mode_d  = pif.ondetect;
          cnt_d   = ONE_C;
          state_d = PEND;
        end
      end
      PEND: begin
        if (pif.in_sig == tgt_q) begin
          if (cnt_q == dly(tgt_q)) begin
            out_sig_d = tgt_q;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end else if ((REJECT_LIM != 0) && (cnt_q < REJ_C)) begin
          cancel_d = 1'b1;
          state_d  = IDLE;
        end else if (mode_q) begin
          out_err_d = 1'b1;
          clr_d     = cnt_q + dly(out_sig_q);
          cnt_d     = cnt_q + ONE_C;
          state_d   = ERR;
        end else if ((cnt_q + dly(out_sig_q)) <= dly(tgt_q)) begin
          cancel_d = 1'b1;
          state_d  = IDLE;
        end else begin
          clr_d   = cnt_q + dly(out_sig_q);
          cnt_d   = cnt_q + ONE_C;
          state_d = ERR_WAIT;
        end
      end
      // >= rather than == so a pulse reverting exactly at maturity still exits.
      ERR_WAIT: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q >= dly(tgt_q)) begin
          out_err_d = 1'b1;
          state_d   = ERR;
        end
      end
      ERR: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q >= clr_q) begin
          out_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pif.out_sig      = out_sig_q;
    pif.out_err      = out_err_q;
    pif.cancel_pulse = cancel_q;
    pif.busy         = (state_q != IDLE);
  end

endmodule

// File: tb/tb_path_pulse_filter.sv
// Scoreboard bench: an event-time reference model predicts outputs per edge,
// a monitor compares them one edge later.
module tb_path_pulse_filter;
  localparam int RISE = 4;
  localparam int FALL = 6;
  localparam int REJ  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  path_pulse_filter_if pif ();

  path_pulse_filter #(
    .RISE_DLY(RISE), .FALL_DLY(FALL), .REJECT_LIM(REJ), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  logic [3:0] exp_q[$];

  // Reference model state: absolute edge times of scheduled events.
  logic m_out, m_err, m_cancel, m_pend, m_errp, m_tgt, m_mode;
  int   t_s, err_on, err_off;

  function automatic int d_of(input logic v);
    return v ? RISE : FALL;
  endfunction

  task automatic model_step(input logic r, input logic i, input logic od);
    int w;
    m_cancel = 1'b0;
    if (r) begin
      m_out = 0; m_err = 0; m_pend = 0; m_errp = 0;
    end else if (m_errp) begin
      if (n == err_on) m_err = 1'b1;
      if (n == err_off) begin
        m_err = 1'b0;
        m_errp = 1'b0;
      end
    end else if (m_pend) begin
      w = n - t_s;
      if (i == m_tgt) begin
        if (w == d_of(m_tgt)) begin
          m_out = m_tgt;
          m_pend = 1'b0;
        end
      end else begin
        m_pend = 1'b0;
        if (w < REJ) begin
          m_cancel = 1'b1;
        end else if (m_mode) begin
          m_err = 1'b1;
          m_errp = 1'b1;
          err_on = n;
          err_off = n + d_of(m_out);
        end else if (w + d_of(m_out) <= d_of(m_tgt)) begin
          m_cancel = 1'b1;
        end else begin
          // Leading event time, but never earlier than the edge after the revert.
          m_errp = 1'b1;
          err_on = (t_s + d_of(m_tgt) > n) ? t_s + d_of(m_tgt) : n + 1;
          err_off = (n + d_of(m_out) > err_on) ? n + d_of(m_out) : err_on + 1;
        end
      end
    end else if (i != m_out) begin
      m_pend = 1'b1;
      t_s = n;
      m_tgt = i;
      m_mode = od;
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic od);
    @(negedge clk);
    rst = r;
    pif.in_sig = i;
    pif.ondetect = od;
    n++;
    model_step(r, i, od);
    exp_q.push_back({m_out, m_err, m_cancel, m_pend | m_errp});
  endtask

  task automatic hold(input int cycles, input logic i, input logic od);
    for (int k = 0; k < cycles; k++) drive(1'b0, i, od);
  endtask

  initial begin : monitor
    logic [3:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {pif.out_sig, pif.out_err, pif.cancel_pulse, pif.busy};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL outputs{out,err,cancel,busy} t=%0t got %b expected %b", $time, g, e);
        end
        $display("edge %0t in=%b od=%b rst=%b -> out/err/cancel/busy=%b", $time,
                 pif.in_sig, pif.ondetect, rst, g);
      end
    end
  end

  initial begin
    logic v, od;
    int len;
    pif.in_sig = 1'b0;
    pif.ondetect = 1'b0;
    m_out = 0; m_err = 0; m_cancel = 0; m_pend = 0; m_errp = 0;
    m_tgt = 0; m_mode = 0; t_s = 0; err_on = 0; err_off = 0;
    // Reset held with toggling input, then idle.
    drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b1, 1'b0);
    hold(5, 1'b0, 1'b0);
    // Plain rise then fall.
    hold(10, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0);
    // ondetect: w=1 rejected, w=3 marked.
    hold(1, 1'b1, 1'b1); hold(10, 1'b0, 1'b1);
    hold(3, 1'b1, 1'b1); hold(12, 1'b0, 1'b1);
    // onevent: w=3 marked late.
    hold(3, 1'b1, 1'b0); hold(12, 1'b0, 1'b0);
    // onevent cancel with out_sig=1.
    hold(8, 1'b1, 1'b0); hold(2, 1'b0, 1'b0); hold(12, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0);
    // Reset in mid-PEND.
    hold(2, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0); hold(8, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0);
    // Random pulse trains with occasional reset.
    v = 1'b0;
    for (int s = 0; s < 400; s++) begin
      v = ~v;
      len = $urandom_range(1, 9);
      od = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) drive(($urandom_range(0, 199) == 0), v, od);
    end
    hold(15, v, 1'b0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/path_pulse_filter.md
Name: path_pulse_filter

Overview:
- Synthesizable cycle-based model of a single specify module path (in => out) with separate rise and fall delays, plus PATHPULSE$-style inertial pulse handling.
- Implements pulsestyle_ondetect/onevent and showcancelled semantics.
- Sits directly downstream of a path's source signal and feeds path-delayed values to the timing-check and compare logic.
- Delays are counted in clock cycles.

Parameters:
- RISE_DLY, 4, cycles from sampled 0->1 input change to out_sig update (>=1).
- FALL_DLY, 6, cycles from sampled 1->0 input change to out_sig update (>=1).
- REJECT_LIM, 2, pulses narrower than this many cycles are cancelled silently; 0 = never reject; must be <= min(RISE_DLY, FALL_DLY).
- CNT_W, 8, counter width; RISE_DLY + FALL_DLY must be < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_sig  in  1  path input, sampled every edge
- ondetect  in  1  1 = pulsestyle_ondetect, 0 = onevent; latched on entry to PEND
- out_sig  out  1  delayed path output
- out_err  out  1  X-equivalent flag; high while output is unknown
- cancel_pulse  out  1  one-cycle strobe on a cancelled pulse (showcancelled event)
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; out_sig=0, out_err=0, cancel_pulse=0, cnt=0.
  - Any pending event is discarded, including one in mid-PEND or mid-ERR.
- Notation:
  - "Edge t" is the clock edge at which the change is sampled.
  - D(v) = RISE_DLY if v=1, else FALL_DLY.
- cancel_pulse defaults to 0 every cycle unless set below.
- IDLE:
  - If in_sig != out_sig at edge t, then tgt <= in_sig, mode <= ondetect, cnt <= 1, go to PEND.
  - At edge t+k, cnt == k.
- PEND, each edge:
  - If in_sig == tgt and cnt == D(tgt): out_sig <= tgt, go to IDLE. Output therefore changes at edge t+D(tgt).
  - Else if in_sig == tgt: cnt++.
  - Else (input reverted, pulse width w = cnt):
    - w < REJECT_LIM: cancel_pulse <= 1; go to IDLE; out_sig unchanged.
    - mode=1 (ondetect): out_err <= 1 at this edge; clr <= w + D(out_sig); cnt++; go to ERR.
    - mode=0 (onevent) and w + D(out_sig) <= D(tgt): trailing event precedes leading, so cancel. cancel_pulse <= 1; go to IDLE.
    - mode=0 otherwise: clr <= w + D(out_sig); cnt++; go to ERR_WAIT.
- ERR_WAIT:
  - cnt++ each edge.
  - When cnt == D(tgt): out_err <= 1, go to ERR.
- ERR:
  - cnt++ each edge.
  - When cnt == clr: out_err <= 0, go to IDLE.
  - out_sig is never changed by the error path.
- Input edges during ERR_WAIT/ERR are ignored. On return to IDLE, the next edge re-evaluates in_sig != out_sig, so a stable changed input schedules normally from that edge.
- Only one event is pending at a time (inertial model). A transition not reverted before maturity propagates exactly once.
- All outputs are registered. There is no combinational in->out path.

Test Plan (defaults RISE=4, FALL=6, REJECT=2):
- rst held 3 cycles, in_sig toggling -> out_sig=0, out_err=0, cancel_pulse=0, busy=0 throughout; after release with in_sig=0, stays idle.
- in_sig 0->1 at edge 10, held -> out_sig=1 at edge 14, busy 10..13. Then 1->0 at edge 20 -> out_sig=0 at edge 26.
- ondetect=1; in_sig high at edge 10, low at edge 11 (w=1) -> cancel_pulse=1 at edge 11 only; out_sig stays 0, out_err stays 0.
- ondetect=1; high at edge 10, low at edge 13 (w=3) -> out_err=1 from edge 13 through edge 18, cleared at edge 19; out_sig stays 0.
- ondetect=0; same pulse -> out_err=1 from edge 14, cleared at edge 19.
- ondetect=0, out_sig=1; in_sig low at edge 30, high at edge 32 (w=2; 2+4 <= 6) -> cancel_pulse at edge 32, no out_err, out_sig stays 1.
- Additionally: rst asserted at edge 12 during a PEND started at edge 10 -> all outputs 0 at edge 12, no late update at edge 14.
